// File: rtl/versatile_mem_ctrl_sdram_fe.sv
// SDRAM-clock front end: drains the per-port egress queues round-robin, issues per-beat SDRAM
// commands, and routes returned read data back to the requesting port's ingress queue.
module versatile_mem_ctrl_sdram_fe #(
  parameter int nr_of_wb_ports = 3
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_rst,
  input  logic [35:0]                 sdram_dat_i,
  input  logic [0:nr_of_wb_ports-1]   sdram_fifo_empty,
  output logic                        sdram_fifo_rd_adr,
  output logic                        sdram_fifo_rd_data,
  output logic [0:nr_of_wb_ports-1]   sdram_fifo_re,
  output logic [31:0]                 sdram_dat_o,
  output logic                        sdram_fifo_wr,
  output logic [0:nr_of_wb_ports-1]   sdram_fifo_we,
  output logic                        mem_cmd_valid,
  input  logic                        mem_cmd_ready,
  output logic                        mem_cmd_we,
  output logic [29:0]                 mem_cmd_adr,
  output logic [31:0]                 mem_cmd_dat,
  output logic [3:0]                  mem_cmd_sel,
  output logic                        mem_cmd_last,
  input  logic                        mem_rd_valid,
  input  logic [31:0]                 mem_rd_dat
);

  localparam int PW = (nr_of_wb_ports > 1) ? $clog2(nr_of_wb_ports) : 1;

  typedef enum logic [2:0] {IDLE, ADR, WR_POP, WR_DAT, WR_CMD, RD_CMD, RD_WAIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] last_port, cur_port, pick;
  logic          pick_vld;
  logic [4:0]    len_r, rcnt;
  logic [3:0]    cnt, beat;
  logic [29:0]   adr_r;
  logic [3:0]    sel_r;
  logic [31:0]   dat_r;
  logic          rd_push;

  function automatic logic [4:0] burst_len(input logic [1:0] bte, input logic [2:0] cti);
    if (cti == 3'b000 || bte == 2'b00) return 5'd1;
    case (bte)
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Wrapping bursts only advance the low log2(len) address bits.
  function automatic logic [29:0] beat_adr(input logic [29:0] adr, input logic [4:0] len,
                                           input logic [3:0] bt);
    logic [29:0] a;
    a = adr;
    case (len)
      5'd4:    a[1:0] = adr[1:0] + bt[1:0];
      5'd8:    a[2:0] = adr[2:0] + bt[2:0];
      5'd16:   a[3:0] = adr[3:0] + bt;
      default: a = adr;
    endcase
    return a;
  endfunction

  function automatic logic [0:nr_of_wb_ports-1] onehot(input logic [PW-1:0] p);
    logic [0:nr_of_wb_ports-1] v;
    v = '0;
    for (int i = 0; i < nr_of_wb_ports; i++)
      if (p == i[PW-1:0]) v[i] = 1'b1;
    return v;
  endfunction

  // Lowest non-empty port above the last served one wins, else lowest non-empty overall.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = nr_of_wb_ports - 1; i >= 0; i--)
      if (!sdram_fifo_empty[i]) begin
        pick     = i[PW-1:0];
        pick_vld = 1'b1;
      end
    for (int i = nr_of_wb_ports - 1; i >= 0; i--)
      if (!sdram_fifo_empty[i] && i > int'(last_port)) pick = i[PW-1:0];
  end

  always_comb begin
    state_nxt          = state;
    rd_push            = 1'b0;
    sdram_fifo_rd_adr  = 1'b0;
    sdram_fifo_rd_data = 1'b0;
    sdram_fifo_re      = '0;
    sdram_fifo_wr      = 1'b0;
    sdram_fifo_we      = '0;
    sdram_dat_o        = '0;
    mem_cmd_valid      = 1'b0;
    mem_cmd_we         = 1'b0;
    mem_cmd_adr        = '0;
    mem_cmd_dat        = '0;
    mem_cmd_sel        = '0;
    mem_cmd_last       = 1'b0;
    if (!sdram_rst) begin
      case (state)
        IDLE: if (pick_vld) begin
          sdram_fifo_rd_adr = 1'b1;
          sdram_fifo_re     = onehot(pick);
          state_nxt         = ADR;
        end
        ADR: state_nxt = sdram_dat_i[5] ? WR_POP : RD_CMD;
        WR_POP: if (!sdram_fifo_empty[cur_port]) begin
          sdram_fifo_rd_data = 1'b1;
          sdram_fifo_re      = onehot(cur_port);
          state_nxt          = WR_DAT;
        end
        WR_DAT: state_nxt = WR_CMD;
        WR_CMD: begin
          mem_cmd_valid = 1'b1;
          mem_cmd_we    = 1'b1;
          mem_cmd_adr   = beat_adr(adr_r, len_r, beat);
          mem_cmd_dat   = dat_r;
          mem_cmd_sel   = sel_r;
          mem_cmd_last  = (cnt == 4'd0);
          if (mem_cmd_ready) state_nxt = (cnt == 4'd0) ? IDLE : WR_POP;
        end
        RD_CMD: begin
          mem_cmd_valid = 1'b1;
          mem_cmd_adr   = beat_adr(adr_r, len_r, beat);
          mem_cmd_sel   = 4'hF;
          mem_cmd_last  = (cnt == 4'd0);
          rd_push       = mem_rd_valid;
          if (mem_cmd_ready && cnt == 4'd0) state_nxt = RD_WAIT;
        end
        RD_WAIT: begin
          rd_push = mem_rd_valid;
          if (rcnt == len_r) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (rd_push) begin
      sdram_fifo_wr = 1'b1;
      sdram_fifo_we = onehot(cur_port);
      sdram_dat_o   = mem_rd_dat;
    end
  end

  // Control state: burst counters, port pointers
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state     <= IDLE;
      last_port <= PW'(nr_of_wb_ports - 1);
      cur_port  <= '0;
      len_r     <= '0;
      cnt       <= '0;
      beat      <= '0;
      rcnt      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_vld) begin
          cur_port  <= pick;
          last_port <= pick;
        end
        ADR: begin
          len_r <= burst_len(sdram_dat_i[4:3], sdram_dat_i[2:0]);
          cnt   <= 4'(burst_len(sdram_dat_i[4:3], sdram_dat_i[2:0]) - 5'd1);
          beat  <= '0;
          rcnt  <= '0;
        end
        WR_CMD, RD_CMD: if (mem_cmd_ready && cnt != 4'd0) begin
          cnt  <= cnt - 4'd1;
          beat <= beat + 4'd1;
        end
        default: ;
      endcase
      if (rd_push) rcnt <= rcnt + 5'd1;
    end
  end

  // Data capture from the egress queue output, one cycle after each pop
  always_ff @(posedge sdram_clk) begin
    if (state == ADR) adr_r <= sdram_dat_i[35:6];
    if (state == WR_DAT) begin
      sel_r <= sdram_dat_i[35:32];
      dat_r <= sdram_dat_i[31:0];
    end
  end

endmodule

// File: tb/tb_versatile_mem_ctrl_sdram_fe.sv
// Directed bench for the SDRAM front end: queue/memory models driven from one process,
// with logged commands, pops and pushes checked against hand-computed values.
module tb_versatile_mem_ctrl_sdram_fe;

  typedef struct packed {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        last;
  } cmd_t;

  logic        clk;
  logic        sdram_rst;
  logic [35:0] sdram_dat_i;
  logic [0:2]  sdram_fifo_empty;
  logic        sdram_fifo_rd_adr, sdram_fifo_rd_data;
  logic [0:2]  sdram_fifo_re;
  logic [31:0] sdram_dat_o;
  logic        sdram_fifo_wr;
  logic [0:2]  sdram_fifo_we;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_cmd_last;
  logic [29:0] mem_cmd_adr;
  logic [31:0] mem_cmd_dat;
  logic [3:0]  mem_cmd_sel;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_dat;

  logic [35:0] eq0[$], eq1[$], eq2[$];
  cmd_t        cmd_log[$];
  logic [31:0] push_dat[$];
  logic [0:2]  push_we[$];
  int          adr_pops[$];
  logic [29:0] rd_pend[$];
  bit          rd_auto;
  int          n_tests, n_fail;

  logic [29:0] exp_w8 [8] = '{30'h2D, 30'h2E, 30'h2F, 30'h28, 30'h29, 30'h2A, 30'h2B, 30'h2C};
  logic [29:0] exp_r4 [4] = '{30'h6, 30'h7, 30'h4, 30'h5};

  versatile_mem_ctrl_sdram_fe #(.nr_of_wb_ports(3)) dut (
    .sdram_clk(clk), .sdram_rst(sdram_rst), .sdram_dat_i(sdram_dat_i),
    .sdram_fifo_empty(sdram_fifo_empty), .sdram_fifo_rd_adr(sdram_fifo_rd_adr),
    .sdram_fifo_rd_data(sdram_fifo_rd_data), .sdram_fifo_re(sdram_fifo_re),
    .sdram_dat_o(sdram_dat_o), .sdram_fifo_wr(sdram_fifo_wr), .sdram_fifo_we(sdram_fifo_we),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_adr(mem_cmd_adr), .mem_cmd_dat(mem_cmd_dat), .mem_cmd_sel(mem_cmd_sel),
    .mem_cmd_last(mem_cmd_last), .mem_rd_valid(mem_rd_valid), .mem_rd_dat(mem_rd_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] aw(input logic [29:0] a, input logic we,
                                     input logic [1:0] bte, input logic [2:0] cti);
    return {a, we, bte, cti};
  endfunction

  function automatic logic [31:0] rdat(input logic [29:0] a);
    return 32'hA500_0000 | {2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd_empty();
    sdram_fifo_empty = {eq0.size() == 0, eq1.size() == 0, eq2.size() == 0};
  endtask

  task automatic clr();
    cmd_log.delete(); push_dat.delete(); push_we.delete(); adr_pops.delete();
  endtask

  // One clock: sample outputs at the falling edge, then update models just after the rising edge.
  task automatic tick();
    logic do_pop;
    int   pp;
    cmd_t c;
    @(negedge clk);
    do_pop = sdram_fifo_rd_adr | sdram_fifo_rd_data;
    pp = 0;
    for (int i = 0; i < 3; i++) if (sdram_fifo_re[i]) pp = i;
    if (sdram_fifo_rd_adr) adr_pops.push_back(pp);
    if (mem_cmd_valid && mem_cmd_ready) begin
      c = {mem_cmd_we, mem_cmd_adr, mem_cmd_dat, mem_cmd_sel, mem_cmd_last};
      cmd_log.push_back(c);
      if (!mem_cmd_we) rd_pend.push_back(mem_cmd_adr);
    end
    if (sdram_fifo_wr) begin
      push_dat.push_back(sdram_dat_o);
      push_we.push_back(sdram_fifo_we);
    end
    @(posedge clk);
    #1;
    if (do_pop) begin
      sdram_dat_i = '0;
      case (pp)
        0: if (eq0.size() > 0) sdram_dat_i = eq0.pop_front();
        1: if (eq1.size() > 0) sdram_dat_i = eq1.pop_front();
        default: if (eq2.size() > 0) sdram_dat_i = eq2.pop_front();
      endcase
    end
    mem_rd_valid = 1'b0;
    if (rd_auto && rd_pend.size() > 0) begin
      mem_rd_valid = 1'b1;
      mem_rd_dat   = rdat(rd_pend.pop_front());
    end
    upd_empty();
  endtask

  task automatic run_cmds(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (cmd_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 96'(cmd_log.size()), 96'(n));
  endtask

  task automatic chk_cmd(input string tag, input int i, input logic we, input logic [29:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic last);
    cmd_t c;
    c = '0;
    if (i < cmd_log.size()) c = cmd_log[i];
    if (!we) c.dat = dat;
    chk(tag, 96'({c.we, c.adr, c.dat, c.sel, c.last}), 96'({we, adr, dat, sel, last}));
  endtask

  task automatic chk_push(input string tag, input int i, input logic [0:2] we, input logic [31:0] d);
    logic [34:0] g;
    g = '1;
    if (i < push_dat.size()) g = {push_we[i], push_dat[i]};
    chk(tag, 96'(g), 96'({we, d}));
  endtask

  task automatic chk_pop(input string tag, input int i, input int port);
    int g;
    g = -1;
    if (i < adr_pops.size()) g = adr_pops[i];
    chk(tag, 96'(g), 96'(port));
  endtask

  function automatic logic [95:0] all_outs();
    return 96'({sdram_fifo_rd_adr, sdram_fifo_rd_data, sdram_fifo_re, sdram_dat_o, sdram_fifo_wr,
                sdram_fifo_we, mem_cmd_valid, mem_cmd_we, mem_cmd_adr, mem_cmd_sel, mem_cmd_last});
  endfunction

  initial begin
    int  k;
    bit  stable;
    n_tests = 0; n_fail = 0;
    sdram_rst = 1'b1; sdram_dat_i = '0; mem_cmd_ready = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_dat = '0; rd_auto = 1'b0;
    upd_empty();

    // Reset state
    repeat (3) tick();
    #1;
    chk("reset_outs", all_outs() | 96'(mem_cmd_dat), '0);
    sdram_rst = 1'b0;
    tick();
    #1;
    chk("idle_outs", all_outs(), '0);

    // 1: port 0 single write
    clr();
    mem_cmd_ready = 1'b1; rd_auto = 1'b1;
    eq0.push_back(aw(30'h100, 1'b1, 2'b00, 3'b000));
    eq0.push_back({4'hF, 32'hDEADBEEF});
    upd_empty();
    run_cmds("t1_ncmd", 1, 20);
    chk_cmd("t1_cmd", 0, 1'b1, 30'h100, 32'hDEADBEEF, 4'hF, 1'b1);
    chk_pop("t1_port", 0, 0);
    repeat (5) tick();
    #1;
    chk("t1_idle", {mem_cmd_valid, 32'(cmd_log.size())}, {1'b0, 32'd1});

    // 2: port 1 wrap4 read from 6
    clr();
    eq1.push_back(aw(30'h6, 1'b0, 2'b01, 3'b010));
    upd_empty();
    run_cmds("t2_ncmd", 4, 30);
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      chk_cmd($sformatf("t2_cmd%0d", i), i, 1'b0, exp_r4[i], 32'h0, 4'hF, i == 3);
      chk_push($sformatf("t2_push%0d", i), i, 3'b010, rdat(exp_r4[i]));
    end
    chk("t2_npush", 96'(push_dat.size()), 96'd4);

    // 4: port 2 wrap8 write, data queue starves after three beats
    clr();
    eq2.push_back(aw(30'h2D, 1'b1, 2'b10, 3'b010));
    for (int i = 0; i < 3; i++) eq2.push_back({(i % 2 == 1) ? 4'hC : 4'h3, 32'hC0DE_0000 + 32'(i)});
    upd_empty();
    run_cmds("t4_first3", 3, 40);
    repeat (10) tick();
    #1;
    chk("t4_stall", {mem_cmd_valid, 32'(cmd_log.size())}, {1'b0, 32'd3});
    for (int i = 3; i < 8; i++) eq2.push_back({(i % 2 == 1) ? 4'hC : 4'h3, 32'hC0DE_0000 + 32'(i)});
    upd_empty();
    run_cmds("t4_all8", 8, 60);
    for (int i = 0; i < 8; i++)
      chk_cmd($sformatf("t4_cmd%0d", i), i, 1'b1, exp_w8[i], 32'hC0DE_0000 + 32'(i),
              (i % 2 == 1) ? 4'hC : 4'h3, i == 7);

    // 3: round robin across all three ports, port 0 holding two transactions
    repeat (3) tick();
    clr();
    eq0.push_back(aw(30'h10, 1'b1, 2'b00, 3'b000)); eq0.push_back({4'hF, 32'h1111_0000});
    eq0.push_back(aw(30'h11, 1'b1, 2'b00, 3'b000)); eq0.push_back({4'hF, 32'h1111_0001});
    eq1.push_back(aw(30'h20, 1'b1, 2'b00, 3'b000)); eq1.push_back({4'hF, 32'h2222_0000});
    eq2.push_back(aw(30'h30, 1'b1, 2'b00, 3'b000)); eq2.push_back({4'hF, 32'h3333_0000});
    upd_empty();
    run_cmds("t3_ncmd", 4, 80);
    chk_pop("t3_pop0", 0, 0); chk_pop("t3_pop1", 1, 1);
    chk_pop("t3_pop2", 2, 2); chk_pop("t3_pop3", 3, 0);
    chk_cmd("t3_cmd3", 3, 1'b1, 30'h11, 32'h1111_0001, 4'hF, 1'b1);

    // 3b: pointer at port 2, ports 0 and 2 pending -> 0 then 2
    repeat (3) tick();
    clr();
    eq2.push_back(aw(30'h31, 1'b1, 2'b00, 3'b000)); eq2.push_back({4'hF, 32'h3333_0001});
    upd_empty();
    run_cmds("t3b_setup", 1, 20);
    repeat (3) tick();
    clr();
    eq0.push_back(aw(30'h12, 1'b1, 2'b00, 3'b000)); eq0.push_back({4'hF, 32'h1111_0002});
    eq2.push_back(aw(30'h32, 1'b1, 2'b00, 3'b000)); eq2.push_back({4'hF, 32'h3333_0002});
    upd_empty();
    run_cmds("t3b_ncmd", 2, 40);
    chk_pop("t3b_pop0", 0, 0); chk_pop("t3b_pop1", 1, 2);

    // 5: ready held low with a read return arriving mid-command
    repeat (3) tick();
    clr();
    mem_cmd_ready = 1'b0; rd_auto = 1'b0;
    eq1.push_back(aw(30'h20, 1'b0, 2'b01, 3'b010));
    upd_empty();
    k = 0;
    while (!mem_cmd_valid && k < 10) begin tick(); #1; k++; end
    chk("t5_first", {mem_cmd_valid, mem_cmd_adr}, {1'b1, 30'h20});
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0; rd_auto = 1'b1;
    stable = 1'b1;
    repeat (5) begin
      #1;
      if (!(mem_cmd_valid && !mem_cmd_we && mem_cmd_adr == 30'h21 && mem_cmd_sel == 4'hF
            && !mem_cmd_last)) stable = 1'b0;
      tick();
    end
    chk("t5_stable", 96'(stable), 96'd1);
    chk("t5_early_n", 96'(push_dat.size()), 96'd1);
    chk_push("t5_early", 0, 3'b010, rdat(30'h20));
    mem_cmd_ready = 1'b1;
    run_cmds("t5_ncmd", 4, 20);
    repeat (5) tick();
    chk_cmd("t5_last", 3, 1'b0, 30'h23, 32'h0, 4'hF, 1'b1);
    chk_push("t5_push3", 3, 3'b010, rdat(30'h23));
    clr();
    eq0.push_back(aw(30'h50, 1'b1, 2'b00, 3'b000)); eq0.push_back({4'h5, 32'h5555_0000});
    upd_empty();
    run_cmds("t5_after", 1, 20);

    // 6: reset in the middle of a wrap16 read
    repeat (3) tick();
    clr();
    rd_auto = 1'b0;
    eq1.push_back(aw(30'h40, 1'b0, 2'b11, 3'b010));
    upd_empty();
    run_cmds("t6_started", 5, 30);
    eq0.push_back(aw(30'h300, 1'b1, 2'b00, 3'b000)); eq0.push_back({4'hF, 32'h0000_3000});
    eq2.push_back(aw(30'h302, 1'b1, 2'b00, 3'b000)); eq2.push_back({4'hF, 32'h0000_3002});
    upd_empty();
    sdram_rst = 1'b1; rd_auto = 1'b1;
    tick();
    clr();
    #1;
    chk("t6_rst_outs", all_outs() | 96'(mem_cmd_dat), '0);
    tick();
    sdram_rst = 1'b0;
    run_cmds("t6_ncmd", 2, 40);
    repeat (5) tick();
    chk("t6_no_push", 96'(push_dat.size()), 96'd0);
    chk_pop("t6_pop0", 0, 0); chk_pop("t6_pop1", 1, 2);
    chk_cmd("t6_cmd0", 0, 1'b1, 30'h300, 32'h0000_3000, 4'hF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
